// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int DEF_DIGITS = 8;
  localparam int DEF_DIV    = 100000;
  localparam int DEF_GUARD  = 2000;
  localparam int IDX_W      = $clog2(8);

  typedef logic [IDX_W-1:0] digit_idx_t;

  // All anodes off (active-low) for a bank of 'digits' digits, low bits used.
  function automatic logic [7:0] an_off(input int digits);
    return 8'((16'd1 << digits) - 16'd1);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts DIV clocks per scan slot, flags the last cycle of a
// slot (tick) and the leading anti-ghosting window (guard).
module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int GUARD = DEF_GUARD
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic guard
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    guard = (cnt_q < CNT_W'(GUARD));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed common-anode digit scanner: per-slot digit select, shadowed
// display value, per-digit blanking, leading-zero suppression and guard time.
module display_scan
  import display_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DIV    = DEF_DIV,
  parameter int GUARD  = DEF_GUARD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NIBBLE_W*DIGITS-1:0]   data_in,
  input  logic                         load,
  input  logic [DIGITS-1:0]            blank_mask,
  input  logic                         lz_blank,
  output logic [NIBBLE_W-1:0]          hex_out,
  output logic [DIGITS-1:0]            an,
  output logic                         frame_done
);

  localparam logic [DIGITS-1:0] AN_OFF = DIGITS'(an_off(DIGITS));

  logic                        slot_tick;
  logic                        slot_guard;

  digit_idx_t                  idx_q, idx_d;
  logic [NIBBLE_W*DIGITS-1:0]  sh_q, sh_d;
  logic [NIBBLE_W-1:0]         hex_q, hex_d;
  logic [DIGITS-1:0]           an_q, an_d;
  logic                        frame_q, frame_d;

  logic [DIGITS-1:0]           zero_above;
  logic [DIGITS-1:0]           dark;
  logic                        zero_run;
  logic                        last_digit;

  scan_prescaler #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (slot_tick),
    .guard (slot_guard)
  );

  // zero_above[i]: nibbles i..DIGITS-1 of the shadow value are all zero.
  always_comb begin
    zero_run   = 1'b1;
    zero_above = '0;
    dark       = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (sh_q[NIBBLE_W*i +: NIBBLE_W] == '0);
      zero_above[i] = zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      dark[i] = blank_mask[i] | (lz_blank & (i > 0) & zero_above[i]);
    end
  end

  always_comb begin
    last_digit = (idx_q == digit_idx_t'(DIGITS - 1));
    idx_d      = idx_q;
    if (slot_tick) begin
      idx_d = last_digit ? '0 : idx_q + digit_idx_t'(1);
    end

    sh_d = load ? data_in : sh_q;

    // Outputs reflect pre-edge state, so they lag the slot counters by one cycle.
    hex_d = '0;
    an_d  = AN_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == digit_idx_t'(i)) begin
        hex_d = sh_q[NIBBLE_W*i +: NIBBLE_W];
        if (!slot_guard && !dark[i]) begin
          an_d[i] = 1'b0;
        end
      end
    end

    frame_d = slot_tick & last_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      sh_q    <= '0;
      hex_q   <= '0;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      hex_q   <= hex_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign hex_out    = hex_q;
  assign an         = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan with DIGITS=8, DIV=4, GUARD=1.
module tb_display_scan;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int GUARD  = 1;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  blank_mask;
  logic        lz_blank;
  logic [3:0]  hex_out;
  logic [7:0]  an;
  logic        frame_done;

  display_scan #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .GUARD  (GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load       (load),
    .blank_mask (blank_mask),
    .lz_blank   (lz_blank),
    .hex_out    (hex_out),
    .an         (an),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_sh;

  // scoreboard: {frame_done, an, hex_out}
  logic [12:0] exp_q[$];

  // per-run observations
  int          lit_cnt[8];
  logic [3:0]  lit_hex[8];
  logic [7:0]  first_lit;
  int          frames;
  int          frame_cyc[$];
  int          cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_sh  = '0;
    exp_q.delete();
  endtask

  function automatic logic [12:0] model_expect();
    logic [7:0] a;
    logic [3:0] h;
    logic       f;
    logic       dk;
    h  = 4'(m_sh >> (4 * m_idx));
    dk = blank_mask[m_idx] || (lz_blank && m_idx > 0 && (m_sh >> (4 * m_idx)) == 32'd0);
    a  = 8'hFF;
    if (m_cnt >= GUARD && !dk) a[m_idx] = 1'b0;
    f  = (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
    return {f, a, h};
  endfunction

  task automatic model_advance();
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_cnt++;
    end
    if (load) m_sh = data_in;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 8; k++) begin
      lit_cnt[k] = 0;
      lit_hex[k] = 4'h0;
    end
    first_lit = 8'hFF;
    frames    = 0;
    frame_cyc.delete();
    cyc       = 0;
  endtask

  // One clock: push expectation from current inputs, advance model, compare.
  task automatic step();
    logic [12:0] e;
    exp_q.push_back(model_expect());
    model_advance();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("hex_out", 32'(hex_out), 32'(e[3:0]));
    check("an", 32'(an), 32'(e[11:4]));
    check("frame_done", 32'(frame_done), 32'(e[12]));
    if (an != 8'hFF) begin
      if (first_lit == 8'hFF) first_lit = an;
      for (int k = 0; k < 8; k++) begin
        if (!an[k]) begin
          lit_cnt[k]++;
          lit_hex[k] = hex_out;
        end
      end
    end
    if (frame_done) begin
      frames++;
      frame_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [31:0] v);
    data_in = v;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  // Advance until the model sits at (cnt, idx); idx < 0 means any digit.
  task automatic align(input int c, input int i);
    int n;
    n = 0;
    while (!(m_cnt == c && (i < 0 || m_idx == i)) && n < 100) begin
      step();
      n++;
    end
    check("align", 32'(m_cnt == c && (i < 0 || m_idx == i)), 32'd1);
  endtask

  task automatic check_lit(input string tag, input logic [7:0] lit_set);
    for (int k = 0; k < 8; k++) begin
      check(tag, 32'(lit_cnt[k]), lit_set[k] ? 32'd3 : 32'd0);
    end
  endtask

  initial begin
    logic [7:0] exp_an;
    int         slot;

    rst_n      = 1'b0;
    data_in    = '0;
    load       = 1'b0;
    blank_mask = '0;
    lz_blank   = 1'b0;
    model_reset();
    clear_stats();

    repeat (2) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_hex", 32'(hex_out), 32'h0);
    check("rst_frame", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // first lit anode after reset release
    clear_stats();
    run(8);
    check("first_lit", 32'(first_lit), 32'hFE);

    // normal scan
    do_load(32'h1234_5678);
    align(0, 0);
    clear_stats();
    run(32);
    check_lit("scan_lit", 8'hFF);
    for (int k = 0; k < 8; k++) begin
      check("scan_hex", 32'(lit_hex[k]), 32'(8 - k));
    end

    // frame wrap
    clear_stats();
    run(64);
    check("frame_count", 32'(frames), 32'd2);
    if (frame_cyc.size() == 2) begin
      check("frame_spacing", 32'(frame_cyc[1] - frame_cyc[0]), 32'd32);
    end

    // asynchronous reset mid-slot
    align(2, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hFF);
    check("async_rst_hex", 32'(hex_out), 32'h0);
    check("async_rst_frame", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_stats();
    run(8);
    check("first_lit_after_rst", 32'(first_lit), 32'hFE);

    // leading-zero suppression
    lz_blank = 1'b1;
    do_load(32'h0000_0405);
    align(0, 0);
    clear_stats();
    run(32);
    check_lit("lz_lit", 8'h07);
    check("lz_digit1_hex", 32'(lit_hex[1]), 32'h0);
    do_load(32'h0);
    align(0, 0);
    clear_stats();
    run(32);
    check_lit("lz_zero_lit", 8'h01);
    check("lz_zero_hex", 32'(lit_hex[0]), 32'h0);

    // per-digit mask
    lz_blank   = 1'b0;
    blank_mask = 8'h02;
    do_load(32'h1234_5678);
    align(0, 0);
    clear_stats();
    run(32);
    check_lit("mask_lit", 8'hFD);

    // load mid-slot: visible one cycle later, same slot
    blank_mask = 8'h00;
    align(1, 3);
    do_load(32'hFFFF_FFFF);
    step();
    check("mid_load_hex", 32'(hex_out), 32'hF);
    check("mid_load_an", 32'(an), 32'hF7);

    // load coincident with slot advance
    do_load(32'h1234_5678);
    align(DIV - 1, -1);
    slot = (m_idx + 1) % DIGITS;
    do_load(32'hFFFF_FFFF);
    step();
    check("adv_load_hex", 32'(hex_out), 32'hF);
    check("adv_load_guard", 32'(an), 32'hFF);
    step();
    exp_an = 8'hFF;
    exp_an[slot] = 1'b0;
    check("adv_load_an", 32'(an), 32'(exp_an));
    run(2);
    check("adv_load_slot_end", 32'(an), 32'(exp_an));
    step();
    check("adv_load_next_guard", 32'(an), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
